// File: rtl/watch_pkg.sv
// Shared time-of-day types and constants for the watch timebase, display and alarm stages.
package watch_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t h10;
    bcd_t h1;
    bcd_t m10;
    bcd_t m1;
    bcd_t s10;
    bcd_t s1;
  } hhmmss_t;

  localparam int unsigned HOURS_MOD  = 24;
  localparam int unsigned MINSEC_MOD = 60;

  // 24h BCD hour to 12h BCD hour; result is {pm, h10, h1}.
  function automatic logic [8:0] to_12h(bcd_t h10, bcd_t h1);
    logic [4:0] hb;
    logic [4:0] v;
    logic [4:0] o;
    logic       pm_f;
    hb = 5'({1'b0, h10} * 5'd10) + {1'b0, h1};
    if (hb == 5'd0) begin
      v    = 5'd12;
      pm_f = 1'b0;
    end else if (hb < 5'd12) begin
      v    = hb;
      pm_f = 1'b0;
    end else if (hb == 5'd12) begin
      v    = 5'd12;
      pm_f = 1'b1;
    end else begin
      v    = hb - 5'd12;
      pm_f = 1'b1;
    end
    o = (v >= 5'd10) ? (v - 5'd10) : v;
    return {pm_f, ((v >= 5'd10) ? 4'd1 : 4'd0), 4'(o)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter modulo MOD with increment, clear and wrap carry.
// nxt_* expose the value the counter takes at the coming edge.
module bcd_mod_counter
  import watch_pkg::*;
#(
  parameter int unsigned MOD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [3:0] nxt_tens,
  output logic [3:0] nxt_ones,
  output logic       carry
);

  localparam logic [3:0] MAX_T = 4'((MOD - 1) / 10);
  localparam logic [3:0] MAX_O = 4'((MOD - 1) % 10);

  logic at_max;

  // Next-state: clear dominates, then increment with digit and modulo wrap.
  always_comb begin
    at_max   = (tens == MAX_T) && (ones == MAX_O);
    nxt_tens = tens;
    nxt_ones = ones;
    carry    = 1'b0;
    if (clr) begin
      nxt_tens = 4'd0;
      nxt_ones = 4'd0;
    end else if (inc) begin
      if (at_max) begin
        nxt_tens = 4'd0;
        nxt_ones = 4'd0;
        carry    = 1'b1;
      end else if (ones == 4'd9) begin
        nxt_tens = tens + 4'd1;
        nxt_ones = 4'd0;
      end else begin
        nxt_ones = ones + 4'd1;
      end
    end
  end

  // Digit registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else begin
      tens <= nxt_tens;
      ones <= nxt_ones;
    end
  end

endmodule

// File: rtl/watch_timebase.sv
// Time-of-day engine: 1 Hz prescaler, BCD hh:mm:ss, manual set mode and hh:mm alarm pulse.
// Optional build macro WATCH_12H_EN selects 12h hour display with pm flag.
module watch_timebase
  import watch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic        CLK100MHZ,
  input  logic        BTNC,
  input  logic        set_mode,
  input  logic        inc_min,
  input  logic        inc_hour,
  input  logic        alarm_en,
  input  logic [15:0] alarm_bcd,
  output logic [23:0] time_bcd,
  output logic        sec_tick,
  output logic        alarm_hit,
  output logic        pm
);

  localparam int unsigned PRESC_W = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc;
  logic               set_q;
  logic               sec_tick_q;
  logic               alarm_q;

  logic tick;
  logic set_exit;
  logic sec_carry, min_carry, hr_carry;
  logic min_inc, hr_inc;

  hhmmss_t cur;
  hhmmss_t nxt;

  assign tick     = !set_mode && (presc == PRESC_MAX);
  assign set_exit = set_q && !set_mode;
  // In set mode carries are ignored so minute edits never touch hours.
  assign min_inc  = set_mode ? inc_min  : sec_carry;
  assign hr_inc   = set_mode ? inc_hour : min_carry;

  bcd_mod_counter #(.MOD(MINSEC_MOD)) u_sec (
    .clk      (CLK100MHZ),
    .rst      (BTNC),
    .inc      (tick),
    .clr      (set_exit),
    .tens     (cur.s10),
    .ones     (cur.s1),
    .nxt_tens (nxt.s10),
    .nxt_ones (nxt.s1),
    .carry    (sec_carry)
  );

  bcd_mod_counter #(.MOD(MINSEC_MOD)) u_min (
    .clk      (CLK100MHZ),
    .rst      (BTNC),
    .inc      (min_inc),
    .clr      (1'b0),
    .tens     (cur.m10),
    .ones     (cur.m1),
    .nxt_tens (nxt.m10),
    .nxt_ones (nxt.m1),
    .carry    (min_carry)
  );

  bcd_mod_counter #(.MOD(HOURS_MOD)) u_hour (
    .clk      (CLK100MHZ),
    .rst      (BTNC),
    .inc      (hr_inc),
    .clr      (1'b0),
    .tens     (cur.h10),
    .ones     (cur.h1),
    .nxt_tens (nxt.h10),
    .nxt_ones (nxt.h1),
    .carry    (hr_carry)
  );

  // Prescaler held at zero while setting, so the first tick lands TICK_DIV cycles after exit.
  always_ff @(posedge CLK100MHZ) begin
    if (BTNC) begin
      presc <= '0;
    end else if (set_mode || presc == PRESC_MAX) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  // Tick, set-mode history and alarm pulse registers. The alarm compares the post-tick
  // time so the pulse coincides with the update; valid counters never match invalid BCD.
  always_ff @(posedge CLK100MHZ) begin
    if (BTNC) begin
      set_q      <= 1'b0;
      sec_tick_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      set_q      <= set_mode;
      sec_tick_q <= tick;
      alarm_q    <= tick && alarm_en && ({nxt.h10, nxt.h1, nxt.m10, nxt.m1} == alarm_bcd) &&
                    (nxt.s10 == 4'd0) && (nxt.s1 == 4'd0);
    end
  end

  assign sec_tick  = sec_tick_q;
  assign alarm_hit = alarm_q;

`ifdef WATCH_12H_EN
  logic [8:0] disp_h;

  // Display hours converted from the next 24h value so latency matches the counters.
  always_ff @(posedge CLK100MHZ) begin
    if (BTNC) begin
      disp_h <= to_12h(4'd0, 4'd0);
    end else begin
      disp_h <= to_12h(nxt.h10, nxt.h1);
    end
  end

  assign time_bcd = {disp_h[7:0], cur.m10, cur.m1, cur.s10, cur.s1};
  assign pm       = disp_h[8];
`else
  assign time_bcd = cur;
  assign pm       = 1'b0;
`endif

  logic unused_carry;
  assign unused_carry = hr_carry;

endmodule

// File: tb/tb_watch_timebase.sv
// Scoreboard bench for watch_timebase with TICK_DIV=4; build with WATCH_12H_EN to test 12h display.
module tb_watch_timebase;

  localparam int unsigned TD = 4;

  logic        clk = 1'b0;
  logic        btnc = 1'b1;
  logic        set_mode = 1'b0;
  logic        inc_min = 1'b0;
  logic        inc_hour = 1'b0;
  logic        alarm_en = 1'b0;
  logic [15:0] alarm_bcd = 16'h0000;
  logic [23:0] time_bcd;
  logic        sec_tick;
  logic        alarm_hit;
  logic        pm;

  int total = 0;
  int bad = 0;
  int alarm_cnt = 0;

  // Reference state.
  int m_hh = 0, m_mm = 0, m_ss = 0, m_presc = 0;
  bit m_setq = 0;

  // Expected {pm, alarm, tick, time}.
  logic [26:0] exp_q[$];

  watch_timebase #(.TICK_DIV(TD)) dut (
    .CLK100MHZ (clk),
    .BTNC      (btnc),
    .set_mode  (set_mode),
    .inc_min   (inc_min),
    .inc_hour  (inc_hour),
    .alarm_en  (alarm_en),
    .alarm_bcd (alarm_bcd),
    .time_bcd  (time_bcd),
    .sec_tick  (sec_tick),
    .alarm_hit (alarm_hit),
    .pm        (pm)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Returns -1 for non-BCD or out-of-range value.
  function automatic int bcd_val(logic [7:0] b, int lim);
    int v;
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
    v = int'(b[7:4]) * 10 + int'(b[3:0]);
    if (v >= lim) return -1;
    return v;
  endfunction

  // Advance the model by one edge with the current inputs and push the expectation.
  task automatic model_push();
    bit tick, fall, alm, epm;
    int ah, am, dh;
    tick = 0;
    alm  = 0;
    if (btnc) begin
      m_hh = 0; m_mm = 0; m_ss = 0; m_presc = 0; m_setq = 0;
    end else begin
      tick = !set_mode && (m_presc == TD - 1);
      fall = m_setq && !set_mode;
      if (set_mode) begin
        m_presc = 0;
        if (inc_min) m_mm = (m_mm + 1) % 60;
        if (inc_hour) m_hh = (m_hh + 1) % 24;
      end else begin
        if (tick) begin
          m_presc = 0;
          m_ss++;
          if (m_ss == 60) begin
            m_ss = 0;
            m_mm++;
            if (m_mm == 60) begin
              m_mm = 0;
              m_hh = (m_hh + 1) % 24;
            end
          end
        end else begin
          m_presc++;
        end
        if (fall) m_ss = 0;
      end
      ah  = bcd_val(alarm_bcd[15:8], 24);
      am  = bcd_val(alarm_bcd[7:0], 60);
      alm = tick && alarm_en && ah >= 0 && am >= 0 && m_ss == 0 && m_hh == ah && m_mm == am;
      m_setq = set_mode;
    end
`ifdef WATCH_12H_EN
    if (m_hh == 0) begin dh = 12; epm = 0; end
    else if (m_hh < 12) begin dh = m_hh; epm = 0; end
    else if (m_hh == 12) begin dh = 12; epm = 1; end
    else begin dh = m_hh - 12; epm = 1; end
`else
    dh  = m_hh;
    epm = 0;
`endif
    exp_q.push_back({epm, alm, tick, to_bcd(dh), to_bcd(m_mm), to_bcd(m_ss)});
  endtask

  task automatic step();
    logic [26:0] e;
    model_push();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("time", {8'h0, time_bcd}, {8'h0, e[23:0]});
    check_val("sec_tick", {31'h0, sec_tick}, {31'h0, e[24]});
    check_val("alarm_hit", {31'h0, alarm_hit}, {31'h0, e[25]});
    check_val("pm", {31'h0, pm}, {31'h0, e[26]});
    if (alarm_hit === 1'b1) alarm_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    btnc = 1'b1;
    run(2);
    btnc = 1'b0;
  endtask

  task automatic pulse(input bit pm_min, input bit ph);
    inc_min  = pm_min;
    inc_hour = ph;
    step();
    inc_min  = 1'b0;
    inc_hour = 1'b0;
    step();
  endtask

  task automatic alarm_run(input logic [15:0] a, input bit en, input int exp_hits,
                           input string tag);
    alarm_bcd = a;
    alarm_en  = en;
    do_reset();
    alarm_cnt = 0;
    run(121 * TD + 4);
    check_val(tag, alarm_cnt, exp_hits);
    alarm_en = 1'b0;
  endtask

  initial begin
    // Reset and tick cadence.
    do_reset();
    check_val("reset_time", {8'h0, time_bcd}, 32'h0);
    run(3 * TD);

    // Rollover: set 23:59, exit, run through midnight.
    set_mode = 1'b1;
    step();
    for (int i = 0; i < 23; i++) pulse(1'b0, 1'b1);
    for (int i = 0; i < 59; i++) pulse(1'b1, 1'b0);
    set_mode = 1'b0;
    step();
    check_val("set_2359", {8'h0, time_bcd}, 32'h235900);
    run(59 * TD);
    check_val("at_235959", {8'h0, time_bcd}, 32'h235959);
    run(TD);
    check_val("midnight", {8'h0, time_bcd}, 32'h000000);

    // Set mode from 00:00:37.
    do_reset();
    run(37 * TD);
    check_val("at_37", {8'h0, time_bcd}, 32'h000037);
    set_mode = 1'b1;
    for (int i = 0; i < 61; i++) pulse(1'b1, i == 0);
    for (int i = 0; i < 24; i++) pulse(1'b0, 1'b1);
    run(10);
    check_val("frozen", {8'h0, time_bcd}, 32'h010137);
    check_val("frozen_tick", {31'h0, sec_tick}, 32'h0);
    set_mode = 1'b0;
    step();
    check_val("set_exit", {8'h0, time_bcd}, 32'h010100);
    run(2 * TD);

    // Alarm variants.
    alarm_run(16'h0002, 1'b1, 1, "alarm_hits");
    alarm_run(16'h0002, 1'b0, 0, "alarm_dis_hits");
    alarm_run(16'h2500, 1'b1, 0, "alarm_bad_hits");

    // Reset while setting.
    set_mode = 1'b1;
    run(3);
    pulse(1'b0, 1'b1);
    inc_hour = 1'b1;
    btnc     = 1'b1;
    step();
    inc_hour = 1'b0;
    btnc     = 1'b0;
    run(3 * TD);
    check_val("rst_mid_set", {8'h0, time_bcd}, 32'h0);

    // 13:05 then 00:05 display.
    for (int i = 0; i < 13; i++) pulse(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
`ifdef WATCH_12H_EN
    check_val("h13", {24'h0, time_bcd[23:16]}, 32'h01);
    check_val("h13_pm", {31'h0, pm}, 32'h1);
`else
    check_val("h13", {24'h0, time_bcd[23:16]}, 32'h13);
    check_val("h13_pm", {31'h0, pm}, 32'h0);
`endif
    for (int i = 0; i < 11; i++) pulse(1'b0, 1'b1);
`ifdef WATCH_12H_EN
    check_val("h00", {24'h0, time_bcd[23:16]}, 32'h12);
`else
    check_val("h00", {24'h0, time_bcd[23:16]}, 32'h00);
`endif
    check_val("h00_pm", {31'h0, pm}, 32'h0);
    set_mode = 1'b0;
    run(2 * TD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
